// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer that shares one single-port memory among NUM_REQ requesters.
// Define MEM_ARB_TIMEOUT_EN to abort reads after RD_TIMEOUT cycles in WAIT_RD with an error response.
module mem_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int RD_TIMEOUT = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic                          busy,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_data_in,
  output logic                          mem_we,
  output logic                          mem_read_en,
  input  logic [DATA_WIDTH-1:0]         mem_data_out,
  input  logic                          mem_valid_out
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;
  state_t state, state_nxt;

  logic [IDX_W-1:0]      last_gnt, win, pick;
  logic [IDX_W:0]        pos;
  logic                  any_req;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [NUM_REQ-1:0]    win_onehot;
  logic                  rd_done, rd_abort, rd_limit;

  // Scan from the farthest offset down so the nearest requester after last_gnt is written last and wins.
  always_comb begin
    pick    = last_gnt;
    any_req = 1'b0;
    pos     = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      pos = {1'b0, last_gnt} + (IDX_W+1)'(i);
      if (pos >= (IDX_W+1)'(NUM_REQ))
        pos = pos - (IDX_W+1)'(NUM_REQ);
      if (req[pos[IDX_W-1:0]]) begin
        pick    = pos[IDX_W-1:0];
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (pick == IDX_W'(j)) begin
        sel_we    = req_we[j];
        sel_addr  = req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rd_done   = 1'b0;
    rd_abort  = 1'b0;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = cmd_we ? IDLE : WAIT_RD;
      WAIT_RD: begin
        // Returned data wins over a timeout reached in the same cycle.
        if (mem_valid_out) begin
          rd_done   = 1'b1;
          state_nxt = IDLE;
        end else if (rd_limit) begin
          rd_abort  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      last_gnt  <= IDX_W'(NUM_REQ - 1);
      win       <= '0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != IDLE);
      rsp_valid <= '0;
      if (state == IDLE && any_req) begin
        win       <= pick;
        last_gnt  <= pick;
        cmd_we    <= sel_we;
        cmd_addr  <= sel_addr;
        cmd_wdata <= sel_wdata;
      end
      if (rd_done) begin
        rsp_valid <= win_onehot;
        rsp_data  <= mem_data_out;
      end else if (rd_abort) begin
        rsp_valid <= win_onehot;
        rsp_data  <= '1;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
  logic [CNT_W-1:0] tmo_cnt;

  // Counts WAIT_RD cycles; the abort fires in the RD_TIMEOUT-th cycle spent waiting.
  always_ff @(posedge clk) begin
    if (reset || state != WAIT_RD)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + CNT_W'(1);
  end

  assign rd_limit = (tmo_cnt == CNT_W'(RD_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset)
      rsp_err <= 1'b0;
    else if (rd_done || rd_abort)
      rsp_err <= rd_abort;
  end
`else
  localparam int unused_rd_timeout = RD_TIMEOUT;
  assign rd_limit = 1'b0;
  assign rsp_err  = 1'b0;
`endif

  assign win_onehot  = NUM_REQ'(1) << win;
  assign gnt         = (state == ISSUE) ? win_onehot : '0;
  assign mem_we      = (state == ISSUE) &&  cmd_we;
  assign mem_read_en = (state == ISSUE) && !cmd_we;
  assign mem_addr    = cmd_addr;
  assign mem_data_in = cmd_wdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed vector table, multi-cycle corner sequences and a
// randomized run against a transaction-level round-robin model with a behavioural memory.
module tb_mem_arbiter;
  localparam int N    = 4;
  localparam int AW   = 11;
  localparam int DW   = 8;
  localparam int NCYC = 3000;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]  gnt, rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_err, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in, mem_data_out;
  logic          mem_we, mem_read_en, mem_valid_out;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int            idx;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            lat;
    logic [DW-1:0] rd_byte;
    logic [N-1:0]  exp_gnt;
    logic [N-1:0]  exp_rsp;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_we(mem_we), .mem_read_en(mem_read_en),
    .mem_data_out(mem_data_out), .mem_valid_out(mem_valid_out)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    mem_valid_out = 1'b0; mem_data_out = '0;
  endtask

  task automatic setReq(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic checkOutput(input string name, input logic [N-1:0] egnt, input logic ewe,
                             input logic ere, input logic [N-1:0] ersp, input logic ebusy);
    @(negedge clk);
    cmp({name, ".gnt"},         32'(gnt),         32'(egnt));
    cmp({name, ".mem_we"},      32'(mem_we),      32'(ewe));
    cmp({name, ".mem_read_en"}, 32'(mem_read_en), 32'(ere));
    cmp({name, ".rsp_valid"},   32'(rsp_valid),   32'(ersp));
    cmp({name, ".busy"},        32'(busy),        32'(ebusy));
  endtask

  task automatic checkZero(input string name);
    checkOutput(name, '0, 1'b0, 1'b0, '0, 1'b0);
    cmp({name, ".rsp_data"},    32'(rsp_data),    32'd0);
    cmp({name, ".rsp_err"},     32'(rsp_err),     32'd0);
    cmp({name, ".mem_addr"},    32'(mem_addr),    32'd0);
    cmp({name, ".mem_data_in"}, 32'(mem_data_in), 32'd0);
  endtask

  // One isolated transaction from IDLE, driven from a table record.
  task automatic applyStimulus(input vec_t v);
    step(); clearInputs(); setReq(v.idx, v.we, v.addr, v.wdata);
    checkOutput("vec.idle", '0, 1'b0, 1'b0, '0, 1'b0);
    step(); req = '0;
    checkOutput("vec.issue", v.exp_gnt, v.we, !v.we, '0, 1'b1);
    cmp("vec.mem_addr", 32'(mem_addr), 32'(v.addr));
    if (v.we) begin
      cmp("vec.mem_data_in", 32'(mem_data_in), 32'(v.wdata));
      step();
      checkOutput("vec.done", '0, 1'b0, 1'b0, '0, 1'b0);
    end else begin
      for (int k = 1; k < v.lat; k++) begin
        step();
        checkOutput("vec.wait", '0, 1'b0, 1'b0, '0, 1'b1);
      end
      step(); mem_valid_out = 1'b1; mem_data_out = v.rd_byte;
      checkOutput("vec.valid", '0, 1'b0, 1'b0, '0, 1'b1);
      step(); mem_valid_out = 1'b0; mem_data_out = 8'h00;
      checkOutput("vec.rsp", '0, 1'b0, 1'b0, v.exp_rsp, 1'b0);
      cmp("vec.rsp_data", 32'(rsp_data), 32'(v.rd_byte));
      cmp("vec.rsp_err",  32'(rsp_err),  32'd0);
    end
  endtask

  function automatic int rr(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int j = (last + k) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int order[5] = '{0, 1, 2, 3, 0};
    logic [DW-1:0] memory [2**AW];
    logic [N-1:0] seen_gnt;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, rsp_byte, vo_data;
    int gnt_cyc, gnt_idx, rsp_cyc, rsp_idx, free_at, m_last, vo_cyc, w;
    logic gnt_we_e, rd_open, in_wait;
    logic [N-1:0] egnt, ersp;

    vecs[0] = '{2, 1'b1, 11'h155, 8'hA5, 0, 8'h00, 4'b0100, 4'b0000};
    vecs[1] = '{1, 1'b0, 11'h7FF, 8'h00, 2, 8'h3C, 4'b0010, 4'b0010};
    vecs[2] = '{0, 1'b1, 11'h000, 8'h5A, 0, 8'h00, 4'b0001, 4'b0000};
    vecs[3] = '{3, 1'b0, 11'h001, 8'h00, 1, 8'h00, 4'b1000, 4'b1000};
    vecs[4] = '{2, 1'b0, 11'h2AA, 8'h11, 4, 8'hFF, 4'b0100, 4'b0100};
    vecs[5] = '{3, 1'b1, 11'h7FF, 8'hFF, 0, 8'h00, 4'b1000, 4'b0000};

    clearInputs();
    reset = 1'b1;
    repeat (3) step();
    checkZero("por");
    step(); reset = 1'b0;

    for (int k = 0; k < 6; k++) applyStimulus(vecs[k]);

    // All four requesters hold write requests; last grant went to 3 so the sweep starts at 0.
    step(); clearInputs();
    for (int i = 0; i < N; i++) setReq(i, 1'b1, AW'(11'h100 + i), DW'(8'h10 + i));
    checkOutput("rr.T", '0, 1'b0, 1'b0, '0, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c % 2 == 1) checkOutput("rr.gnt", N'(1) << order[(c-1)/2], 1'b1, 1'b0, '0, 1'b1);
      else            checkOutput("rr.gap", '0, 1'b0, 1'b0, '0, 1'b0);
    end
    step(); clearInputs();

    // Bring last grant back to 3, then requesters 0 and 3 compete: 0 wraps ahead of 3.
    applyStimulus(vecs[5]);
    step(); clearInputs(); setReq(0, 1'b1, 11'h010, 8'h01); setReq(3, 1'b1, 11'h013, 8'h03);
    checkOutput("wrap.T", '0, 1'b0, 1'b0, '0, 1'b0);
    step(); req[0] = 1'b0;
    checkOutput("wrap.first", 4'b0001, 1'b1, 1'b0, '0, 1'b1);
    cmp("wrap.first.addr", 32'(mem_addr), 32'h010);
    step();
    checkOutput("wrap.gap", '0, 1'b0, 1'b0, '0, 1'b0);
    step(); req[3] = 1'b0;
    checkOutput("wrap.second", 4'b1000, 1'b1, 1'b0, '0, 1'b1);
    cmp("wrap.second.addr", 32'(mem_addr), 32'h013);
    step();
    checkOutput("wrap.end", '0, 1'b0, 1'b0, '0, 1'b0);

    // Reset during WAIT_RD drops the read; a late valid_out must not produce a response.
    step(); clearInputs(); setReq(1, 1'b0, 11'h123, 8'h00);
    checkOutput("rst.T", '0, 1'b0, 1'b0, '0, 1'b0);
    step(); req = '0;
    checkOutput("rst.issue", 4'b0010, 1'b0, 1'b1, '0, 1'b1);
    step();
    checkOutput("rst.wait", '0, 1'b0, 1'b0, '0, 1'b1);
    step(); reset = 1'b1;
    step();
    checkZero("rst.mid");
    step(); reset = 1'b0; mem_valid_out = 1'b1; mem_data_out = 8'h99;
    checkZero("rst.after");
    step(); mem_valid_out = 1'b0; mem_data_out = 8'h00;
    checkZero("rst.late");

`ifdef MEM_ARB_TIMEOUT_EN
    step(); clearInputs(); setReq(2, 1'b0, 11'h0AB, 8'h00);
    checkOutput("tmo.T", '0, 1'b0, 1'b0, '0, 1'b0);
    step(); req = '0;
    checkOutput("tmo.issue", 4'b0100, 1'b0, 1'b1, '0, 1'b1);
    for (int k = 1; k <= 15; k++) begin
      step();
      checkOutput("tmo.wait", '0, 1'b0, 1'b0, '0, 1'b1);
    end
    step();
    checkOutput("tmo.rsp", '0, 1'b0, 1'b0, 4'b0100, 1'b0);
    cmp("tmo.rsp_data", 32'(rsp_data), 32'hFF);
    cmp("tmo.rsp_err",  32'(rsp_err),  32'd1);
    step(); mem_valid_out = 1'b1; mem_data_out = 8'h42;
    checkOutput("tmo.late", '0, 1'b0, 1'b0, '0, 1'b0);
    step(); mem_valid_out = 1'b0;
    checkOutput("tmo.ignored", '0, 1'b0, 1'b0, '0, 1'b0);
`endif

    // Randomized traffic against a transaction-level model of the arbiter.
    for (int a = 0; a < 2**AW; a++) memory[a] = DW'($urandom);
    step(); reset = 1'b1; clearInputs();
    step(); step(); reset = 1'b0;
    gnt_cyc = -1; gnt_idx = 0; rsp_cyc = -1; rsp_idx = 0; free_at = 0; m_last = N - 1;
    vo_cyc = -1; vo_data = '0; rd_open = 1'b0; gnt_we_e = 1'b0; e_addr = '0; e_wdata = '0;
    rsp_byte = '0; seen_gnt = '0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (cyc > 0) begin
        step();
        for (int i = 0; i < N; i++) begin
          if (seen_gnt[i])                                 req[i] = 1'b0;
          else if (req[i] && $urandom_range(0, 39) == 0)   req[i] = 1'b0;
          else if (!req[i] && $urandom_range(0, 2) == 0)
            setReq(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
        end
        if (cyc == vo_cyc) begin
          mem_valid_out = 1'b1; mem_data_out = vo_data;
        end else if (!(rd_open && cyc > gnt_cyc) && $urandom_range(0, 7) == 0) begin
          mem_valid_out = 1'b1; mem_data_out = DW'($urandom);
        end else begin
          mem_valid_out = 1'b0; mem_data_out = DW'($urandom);
        end
      end

      in_wait = rd_open && (cyc > gnt_cyc);
      egnt = (cyc == gnt_cyc) ? N'(1) << gnt_idx : '0;
      ersp = (cyc == rsp_cyc) ? N'(1) << rsp_idx : '0;
      checkOutput("rnd", egnt, (cyc == gnt_cyc) && gnt_we_e, (cyc == gnt_cyc) && !gnt_we_e,
                  ersp, (cyc == gnt_cyc) || in_wait);
      if (cyc == gnt_cyc) begin
        cmp("rnd.mem_addr", 32'(mem_addr), 32'(e_addr));
        if (gnt_we_e) cmp("rnd.mem_data_in", 32'(mem_data_in), 32'(e_wdata));
      end
      if (cyc == rsp_cyc) begin
        cmp("rnd.rsp_data", 32'(rsp_data), 32'(rsp_byte));
        cmp("rnd.rsp_err",  32'(rsp_err),  32'd0);
      end

      seen_gnt = gnt;
      if (mem_we) memory[mem_addr] = mem_data_in;
      if (mem_read_en) begin
        vo_cyc  = cyc + int'($urandom_range(1, 4));
        vo_data = memory[mem_addr];
      end
      if (in_wait && mem_valid_out) begin
        rsp_cyc  = cyc + 1;
        rsp_idx  = gnt_idx;
        rsp_byte = mem_data_out;
        rd_open  = 1'b0;
        free_at  = cyc + 1;
      end
      if (!rd_open && cyc >= free_at && req != '0) begin
        w        = rr(req, m_last);
        gnt_cyc  = cyc + 1;
        gnt_idx  = w;
        m_last   = w;
        gnt_we_e = req_we[w];
        e_addr   = req_addr[w*AW +: AW];
        e_wdata  = req_wdata[w*DW +: DW];
        if (gnt_we_e) free_at = cyc + 2;
        else          rd_open = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter and sequencer that shares the single-port 2K x 8 shared memory among NUM_REQ processor requesters in the multiprocessor system. It accepts one read or write at a time and drives the memory's addr/data_in/we/read_en port. For reads it waits for the memory's valid_out and routes the returned byte back to the winning requester. It sits between the processor cores and the memory instance, on the memory's driver-side signal set.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 11, memory address width
- DATA_WIDTH, 8, memory data width
- RD_TIMEOUT, 15, max cycles in WAIT_RD before abort (used only with MEM_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester request; held high until that requester's gnt
- req_we  in  NUM_REQ  1 = write, 0 = read; valid while req high
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data; same packing
- gnt  out  NUM_REQ  one-hot, one-cycle pulse: command accepted
- rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse: read data (or error) for requester i
- rsp_data  out  DATA_WIDTH  read data; valid only with rsp_valid
- rsp_err  out  1  read timed out; valid only with rsp_valid
- busy  out  1  FSM not in IDLE
- mem_addr  out  ADDR_WIDTH  to memory addr
- mem_data_in  out  DATA_WIDTH  to memory data_in
- mem_we  out  1  to memory we
- mem_read_en  out  1  to memory read_en
- mem_data_out  in  DATA_WIDTH  from memory data_out
- mem_valid_out  in  1  from memory valid_out

## Operation
- States: IDLE, ISSUE, WAIT_RD.
- IDLE: if any req bit set, pick winner w by round-robin; register w, req_we[w], addr and wdata of w; go to ISSUE. Otherwise stay.
- Round-robin: search starts at last_gnt+1 and wraps modulo NUM_REQ; first set bit wins. last_gnt <= w on every grant.
- ISSUE (one cycle): gnt[w]=1; mem_addr and mem_data_in hold the registered command. Write: mem_we=1 and go to IDLE. Read: mem_read_en=1 and go to WAIT_RD.
- WAIT_RD: mem_valid_out=1 captures mem_data_out and goes to IDLE. rsp_valid[w]=1 and rsp_data=captured byte on the following cycle, with rsp_err=0.
- mem_valid_out is ignored outside WAIT_RD; a late or stray pulse has no effect.
- mem_we and mem_read_en are never both high, and each is high only in ISSUE.
- req is sampled only in IDLE; a requester dropping req before gnt loses its slot with no side effects.
- Reset: FSM=IDLE, last_gnt=NUM_REQ-1 (requester 0 highest priority first). gnt, rsp_valid, rsp_data, rsp_err, busy, mem_addr, mem_data_in, mem_we, mem_read_en are all 0. An in-flight read is dropped and no rsp_valid is issued. Reset has priority over all transitions.

## Timing
- req seen in IDLE at cycle T: gnt and memory strobe at T+1.
- Write: back in IDLE at T+2; next ISSUE no earlier than T+3. Peak throughput is 1 op / 2 cycles.
- Read: mem_valid_out seen at cycle R gives rsp_valid at R+1 (state IDLE at R+1); next ISSUE no earlier than R+2.
- busy is high in ISSUE and WAIT_RD; it is registered alongside state.

## Configuration
- MEM_ARB_TIMEOUT_EN defined: a counter starts at 0 on entry to WAIT_RD and increments each cycle. If it reaches RD_TIMEOUT without mem_valid_out: rsp_valid[w]=1, rsp_data=8'hFF, rsp_err=1 next cycle, then return to IDLE. If mem_valid_out arrives on the same cycle the limit is reached, the valid data wins.
- Undefined: no counter; WAIT_RD waits indefinitely; rsp_err is tied to 0.

## Test plan
- Reset: assert reset 2 cycles mid-WAIT_RD -> all outputs 0, state IDLE, no rsp_valid; a later mem_valid_out is ignored.
- Single write: req[2]=1, we=1, addr=11'h155, wdata=8'hA5 -> gnt[2] next cycle with mem_we=1, mem_addr=11'h155, mem_data_in=8'hA5; busy returns to 0 one cycle later.
- Single read: req[1] read addr=11'h7FF; memory returns 8'h3C with valid_out 2 cycles after read_en -> rsp_valid[1]=1, rsp_data=8'h3C one cycle after valid_out.
- Fairness: req=4'b1111 held continuously, all writes -> gnt order 0,1,2,3,0 on cycles T+1, T+3, T+5, T+7, T+9.
- Wrap/priority: last grant to 3, then req=4'b1001 -> requester 0 granted next, then requester 3.
- Timeout (MEM_ARB_TIMEOUT_EN, RD_TIMEOUT=15): read with no valid_out -> rsp_valid pulse carrying rsp_data=8'hFF, rsp_err=1 after 15 WAIT_RD cycles; a valid_out arriving afterwards is ignored.
